// File: rtl/mem_bus_if.sv
// Memory-side bus stage: turns sequencer FETCH/EXEC1 requests into Avalon-MM
// reads and writes. It registers fetched instructions and lane-aligned load data.
// Latency: zero-wait fetch/load 3 cycles, store 2, no-access states 1 cycle.
// Backpressure: waitrequest_i holds the request stable, and stall_o holds the sequencer.
// Ports: clk/reset_i; sequencer side state_i, pc_i, data_addr_i, mem_read_i,
//   mem_write_i, size_i, signed_i, store_data_i -> instr_o, load_data_o, stall_o,
//   misalign_o; Avalon side address_o, read_o, write_o, byteenable_o, writedata_o,
//   waitrequest_i, readdata_i.
module mem_bus_if #(
    parameter logic [31:0] RESET_VECTOR = 32'hBFC0_0000
) (
    input  logic        clk,
    input  logic        reset_i,
    input  logic [1:0]  state_i,
    input  logic [31:0] pc_i,
    input  logic [31:0] data_addr_i,
    input  logic        mem_read_i,
    input  logic        mem_write_i,
    input  logic [1:0]  size_i,
    input  logic        signed_i,
    input  logic [31:0] store_data_i,
    input  logic        waitrequest_i,
    input  logic [31:0] readdata_i,
    output logic [31:0] address_o,
    output logic        read_o,
    output logic        write_o,
    output logic [3:0]  byteenable_o,
    output logic [31:0] writedata_o,
    output logic [31:0] instr_o,
    output logic [31:0] load_data_o,
    output logic        stall_o,
    output logic        misalign_o
);

    // Sequencer state encoding (EXEC2 never needs the bus, so it is not decoded).
    localparam logic [1:0] ST_FETCH = 2'd0;
    localparam logic [1:0] ST_EXEC1 = 2'd1;

    // The instruction register resets to a NOP. The vector is kept only as a
    // debug-visible parameter.
    localparam logic [31:0] INSTR_RST = RESET_VECTOR & 32'h0000_0000;

    typedef enum logic [1:0] {S_IDLE, S_ACCEPT, S_DATA, S_DONE} fsm_t;

    fsm_t        r_fsm;
    logic [1:0]  r_cap;      // sequencer state that owns the current/last transfer
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [3:0]  r_be;
    logic        r_rd;
    logic [1:0]  r_lane;
    logic [1:0]  r_size;
    logic        r_sgn;
    logic [31:0] r_instr;
    logic [31:0] r_load;

    logic        w_fresh;
    logic        w_fetch;
    logic        w_ld;
    logic        w_st;
    logic        w_mis;
    logic        w_need;
    logic        w_issue;
    logic        w_is_read;
    logic [1:0]  w_size;
    logic [1:0]  w_lane;
    logic [31:0] w_addr;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;

    function automatic logic [31:0] align_load(input logic [31:0] d, input logic [1:0] lane,
                                               input logic [1:0] sz, input logic sg);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = d[{lane, 3'b000} +: 8];
        h = lane[1] ? d[31:16] : d[15:0];
        case (sz)
            2'b00:   r = {{24{sg & b[7]}}, b};
            2'b01:   r = {{16{sg & h[15]}}, h};
            default: r = d;
        endcase
        return r;
    endfunction

    always_comb begin
        // DONE with a changed sequencer state is decoded like IDLE. This lets the
        // next state's request issue without a bubble. A bubble would show
        // stall_o=0 and let the sequencer slip past the access.
        w_fresh   = (r_fsm == S_IDLE) || ((r_fsm == S_DONE) && (state_i != r_cap));
        w_fetch   = (state_i == ST_FETCH);
        w_ld      = (state_i == ST_EXEC1) && mem_read_i;
        w_st      = (state_i == ST_EXEC1) && mem_write_i && !mem_read_i;
        w_size    = (w_fetch || size_i == 2'b11) ? 2'b10 : size_i;
        w_lane    = data_addr_i[1:0];
        w_mis     = (w_ld || w_st) &&
                    (((w_size == 2'b01) && w_lane[0]) || ((w_size == 2'b10) && (w_lane != 2'b00)));
        w_need    = w_fetch || ((w_ld || w_st) && !w_mis);
        w_issue   = w_fresh && w_need && !reset_i;
        w_is_read = w_fetch || w_ld;
        w_addr    = w_fetch ? (pc_i & ~32'h3) : (data_addr_i & ~32'h3);
        case (w_size)
            2'b00: begin
                w_be    = 4'b0001 << w_lane;
                w_wdata = {4{store_data_i[7:0]}};
            end
            2'b01: begin
                w_be    = w_lane[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{store_data_i[15:0]}};
            end
            default: begin
                w_be    = 4'b1111;
                w_wdata = store_data_i;
            end
        endcase
    end

    // Strobes appear in the issue cycle and are replayed from the registers in
    // ACCEPT. Reset kills them in the same cycle.
    assign read_o       = !reset_i && ((w_issue && w_is_read) || ((r_fsm == S_ACCEPT) && r_rd));
    assign write_o      = !reset_i && ((w_issue && !w_is_read) || ((r_fsm == S_ACCEPT) && !r_rd));
    assign stall_o      = !reset_i && (w_issue || (r_fsm == S_ACCEPT) || (r_fsm == S_DATA));
    assign misalign_o   = !reset_i && w_fresh && w_mis;
    assign address_o    = w_fresh ? w_addr  : r_addr;
    assign byteenable_o = w_fresh ? w_be    : r_be;
    assign writedata_o  = w_fresh ? w_wdata : r_wdata;
    assign instr_o      = r_instr;
    assign load_data_o  = r_load;

    always_ff @(posedge clk) begin
        if (reset_i) begin
            r_fsm   <= S_IDLE;
            r_cap   <= ST_FETCH;
            r_addr  <= 32'h0;
            r_wdata <= 32'h0;
            r_be    <= 4'h0;
            r_rd    <= 1'b0;
            r_lane  <= 2'b00;
            r_size  <= 2'b00;
            r_sgn   <= 1'b0;
            r_instr <= INSTR_RST;
            r_load  <= 32'h0;
        end else begin
            case (r_fsm)
                S_IDLE, S_DONE: begin
                    if (w_fresh) begin
                        if (w_issue) begin
                            r_cap   <= state_i;
                            r_addr  <= w_addr;
                            r_wdata <= w_wdata;
                            r_be    <= w_be;
                            r_rd    <= w_is_read;
                            r_lane  <= w_lane;
                            r_size  <= w_size;
                            r_sgn   <= signed_i;
                            r_fsm   <= waitrequest_i ? S_ACCEPT : (w_is_read ? S_DATA : S_DONE);
                        end else if (w_mis) begin
                            // Park in DONE so the pulse is not repeated while EXEC1 is held.
                            r_cap <= state_i;
                            r_fsm <= S_DONE;
                        end else begin
                            r_fsm <= S_IDLE;
                        end
                    end
                end
                S_ACCEPT: begin
                    if (!waitrequest_i) begin
                        r_fsm <= r_rd ? S_DATA : S_DONE;
                    end
                end
                S_DATA: begin
                    if (r_cap == ST_FETCH) begin
                        r_instr <= readdata_i;
                    end else begin
                        r_load <= align_load(readdata_i, r_lane, r_size, r_sgn);
                    end
                    r_fsm <= S_DONE;
                end
                default: r_fsm <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bus_if.sv
// Bench for mem_bus_if: acts as sequencer and Avalon slave, checks against a reference model.
// Latency: runs one sequencer state at a time until stall_o drops, plus optional hold cycles.
// Backpressure: injects waitrequest_i stretches of 0..3 cycles on every access.
module tb_mem_bus_if;

    localparam logic [1:0] FETCH = 2'd0;
    localparam logic [1:0] EXEC1 = 2'd1;
    localparam logic [1:0] EXEC2 = 2'd2;

    logic        clk = 1'b0;
    logic        reset_i;
    logic [1:0]  state_i;
    logic [31:0] pc_i;
    logic [31:0] data_addr_i;
    logic        mem_read_i;
    logic        mem_write_i;
    logic [1:0]  size_i;
    logic        signed_i;
    logic [31:0] store_data_i;
    logic        waitrequest_i;
    logic [31:0] readdata_i;
    logic [31:0] address_o;
    logic        read_o;
    logic        write_o;
    logic [3:0]  byteenable_o;
    logic [31:0] writedata_o;
    logic [31:0] instr_o;
    logic [31:0] load_data_o;
    logic        stall_o;
    logic        misalign_o;

    int n_checks = 0;
    int n_pass   = 0;
    logic [31:0] exp_instr;
    logic [31:0] exp_load;

    always #5 clk = ~clk;

    mem_bus_if dut (
        .clk           (clk),
        .reset_i       (reset_i),
        .state_i       (state_i),
        .pc_i          (pc_i),
        .data_addr_i   (data_addr_i),
        .mem_read_i    (mem_read_i),
        .mem_write_i   (mem_write_i),
        .size_i        (size_i),
        .signed_i      (signed_i),
        .store_data_i  (store_data_i),
        .waitrequest_i (waitrequest_i),
        .readdata_i    (readdata_i),
        .address_o     (address_o),
        .read_o        (read_o),
        .write_o       (write_o),
        .byteenable_o  (byteenable_o),
        .writedata_o   (writedata_o),
        .instr_o       (instr_o),
        .load_data_o   (load_data_o),
        .stall_o       (stall_o),
        .misalign_o    (misalign_o)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Load result computed arithmetically: extract the lane value and add the sign fill.
    function automatic logic [31:0] ref_load(input logic [31:0] d, input logic [1:0] lane,
                                             input logic [1:0] sz, input logic sg);
        logic [31:0] v;
        if (sz == 2'd0) begin
            v = (d >> (8 * lane)) & 32'hFF;
            if (sg && v >= 32'd128) v = v + 32'hFFFF_FF00;
        end else if (sz == 2'd1) begin
            v = (d >> (16 * lane[1])) & 32'hFFFF;
            if (sg && v >= 32'd32768) v = v + 32'hFFFF_0000;
        end else begin
            v = d;
        end
        return v;
    endfunction

    // Hold one sequencer state until stall_o is low, then for 'hold' more cycles.
    // Called at posedge+1; returns at posedge+1.
    task automatic run_state(input logic [1:0] st, input logic rd, input logic wr,
                             input logic [31:0] addr, input logic [1:0] sz, input logic sg,
                             input logic [31:0] sd, input int waits, input logic [31:0] rdat,
                             input int hold);
        logic        is_fetch, is_ld, is_st, mis, need;
        logic [1:0]  esz;
        logic [31:0] e_addr, e_wdata;
        logic [3:0]  e_be;
        int          n_rd, n_wr, n_stall, n_mis, n_strobe, post, cyc;
        logic        acc_prev, done;

        is_fetch = (st == FETCH);
        is_ld    = (st == EXEC1) && rd;
        is_st    = (st == EXEC1) && wr && !rd;
        esz      = (is_fetch || sz == 2'd3) ? 2'd2 : sz;
        mis      = (is_ld || is_st) && ((esz == 2'd1 && addr[0]) || (esz == 2'd2 && addr[1:0] != 2'd0));
        need     = is_fetch || ((is_ld || is_st) && !mis);
        e_addr   = {addr[31:2], 2'b00};
        e_be     = (esz == 2'd0) ? (4'd1 << addr[1:0]) : (esz == 2'd1) ? (4'd3 << (addr[1] * 2)) : 4'hF;
        e_wdata  = (esz == 2'd0) ? sd[7:0] * 32'h0101_0101 :
                   (esz == 2'd1) ? sd[15:0] * 32'h0001_0001 : sd;

        state_i      = st;
        mem_read_i   = rd;
        mem_write_i  = wr;
        size_i       = sz;
        signed_i     = sg;
        store_data_i = sd;
        pc_i         = is_fetch ? addr : $urandom;
        data_addr_i  = is_fetch ? $urandom : addr;

        n_rd = 0; n_wr = 0; n_stall = 0; n_mis = 0; n_strobe = 0; post = 0; cyc = 0;
        acc_prev = 1'b0; done = 1'b0;
        forever begin
            waitrequest_i = (n_strobe < waits);
            readdata_i    = acc_prev ? rdat : $urandom;
            @(negedge clk);
            if (read_o)  n_rd++;
            if (write_o) n_wr++;
            if (read_o || write_o) begin
                n_strobe++;
                check_eq("address", address_o, e_addr);
                check_eq("byteenable", {28'h0, byteenable_o}, {28'h0, e_be});
                if (write_o) check_eq("writedata", writedata_o, e_wdata);
            end
            if (stall_o)    n_stall++;
            if (misalign_o) n_mis++;
            acc_prev = read_o && !waitrequest_i;
            if (done) post++;
            else if (!stall_o) done = 1'b1;
            if (done && post >= hold) break;
            cyc++;
            if (cyc >= 40) break;
            @(posedge clk); #1;
        end
        check_eq("completed", {31'h0, done}, 32'd1);
        check_eq("read_cycles", n_rd, (need && !is_st) ? waits + 1 : 0);
        check_eq("write_cycles", n_wr, (need && is_st) ? waits + 1 : 0);
        check_eq("stall_cycles", n_stall, !need ? 0 : is_st ? waits + 1 : waits + 2);
        check_eq("misalign_pulses", n_mis, mis ? 1 : 0);
        if (need && is_fetch) exp_instr = rdat;
        if (need && is_ld)    exp_load  = ref_load(rdat, addr[1:0], esz, sg);
        check_eq("instr", instr_o, exp_instr);
        check_eq("load_data", load_data_o, exp_load);
        @(posedge clk); #1;
    endtask

    initial begin
        reset_i = 1'b1; state_i = FETCH; pc_i = 32'h0; data_addr_i = 32'h0;
        mem_read_i = 1'b0; mem_write_i = 1'b0; size_i = 2'd0; signed_i = 1'b0;
        store_data_i = 32'h0; waitrequest_i = 1'b0; readdata_i = 32'h0;
        exp_instr = 32'h0; exp_load = 32'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("rst_read", {31'h0, read_o}, 32'd0);
        check_eq("rst_write", {31'h0, write_o}, 32'd0);
        check_eq("rst_stall", {31'h0, stall_o}, 32'd0);
        check_eq("rst_misalign", {31'h0, misalign_o}, 32'd0);
        check_eq("rst_instr", instr_o, 32'h0);
        check_eq("rst_load", load_data_o, 32'h0);
        @(posedge clk); #1;
        reset_i = 1'b0;

        // Directed sequences.
        run_state(FETCH, 0, 0, 32'h0000_0010, 2'd2, 0, 32'h0, 0, 32'h2402_0005, 0);
        run_state(EXEC1, 0, 0, 32'h0000_0300, 2'd2, 0, 32'h0, 0, 32'h0, 0);
        run_state(EXEC2, 0, 0, 32'h0, 2'd0, 0, 32'h0, 0, 32'h0, 0);
        run_state(FETCH, 0, 0, 32'h0000_0014, 2'd2, 0, 32'h0, 3, 32'h8C43_0004, 2);
        run_state(EXEC1, 1, 0, 32'h0000_0103, 2'd0, 1, 32'h0, 0, 32'h80FF_FF7F, 1);
        run_state(EXEC2, 1, 1, 32'h0, 2'd0, 0, 32'h0, 0, 32'h0, 0);
        run_state(FETCH, 0, 0, 32'h0000_0018, 2'd2, 0, 32'h0, 0, 32'h1111_2222, 0);
        run_state(EXEC1, 1, 0, 32'h0000_0102, 2'd1, 0, 32'h0, 0, 32'h80FF_FF7F, 0);
        run_state(EXEC2, 0, 0, 32'h0, 2'd0, 0, 32'h0, 0, 32'h0, 0);
        run_state(FETCH, 0, 0, 32'h0000_001C, 2'd2, 0, 32'h0, 0, 32'h3333_4444, 0);
        run_state(EXEC1, 0, 1, 32'h0000_0201, 2'd0, 0, 32'h1234_56AB, 0, 32'h0, 1);
        run_state(EXEC2, 0, 0, 32'h0, 2'd0, 0, 32'h0, 0, 32'h0, 0);
        run_state(FETCH, 0, 0, 32'h0000_0020, 2'd2, 0, 32'h0, 1, 32'h5555_6666, 0);
        run_state(EXEC1, 1, 0, 32'h0000_0202, 2'd2, 0, 32'h0, 0, 32'h0, 2);
        run_state(EXEC2, 0, 0, 32'h0, 2'd0, 0, 32'h0, 0, 32'h0, 0);

        // Reset in the middle of a stretched fetch.
        state_i = FETCH; pc_i = 32'h0000_0040; waitrequest_i = 1'b1;
        @(negedge clk);
        check_eq("rst_acc_issue", {31'h0, read_o}, 32'd1);
        @(posedge clk); #1;
        reset_i = 1'b1;
        @(negedge clk);
        check_eq("rst_acc_read", {31'h0, read_o}, 32'd0);
        check_eq("rst_acc_stall", {31'h0, stall_o}, 32'd0);
        @(posedge clk); #1;
        reset_i = 1'b0; state_i = EXEC2; waitrequest_i = 1'b0;
        exp_instr = 32'h0; exp_load = 32'h0;
        @(negedge clk);
        check_eq("post_rst_stall", {31'h0, stall_o}, 32'd0);
        check_eq("post_rst_read", {31'h0, read_o}, 32'd0);
        check_eq("post_rst_instr", instr_o, 32'h0);
        @(posedge clk); #1;

        // Random sequencer rounds.
        for (int i = 0; i < 60; i++) begin
            logic [31:0] a;
            int op;
            a  = $urandom;
            op = $urandom_range(0, 3);
            run_state(FETCH, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom, 2'($urandom_range(0, 3)),
                      1'($urandom_range(0, 1)), $urandom, $urandom_range(0, 3), $urandom, $urandom_range(0, 2));
            run_state(EXEC1, op[0], op[1], a, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                      $urandom, $urandom_range(0, 3), $urandom, $urandom_range(0, 2));
            run_state(EXEC2, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom, 2'd0, 0,
                      $urandom, 0, $urandom, $urandom_range(0, 1));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
